coco_clk_enables: RTL

Clock-enable and reset sequencer on the consuming side of the 42.954545 MHz system PLL (12 × 3.579545 MHz NTSC colour-burst). It watches the PLL `locked` output, holds the system in reset until lock has been stable, then derives the single-cycle enables the rest of the core runs on:

- the VDG pixel enable (3.579545 MHz);
- the 6809 E/Q quadrature clocks, either 0.894886 MHz normal or 1.789773 MHz turbo.

All logic runs in the PLL output domain. No derived clocks are created.

---
 rtl/coco_clk_enables.sv | 139 +++++++++++++
 1 files changed

// File: rtl/coco_clk_enables.sv
// Purpose: PLL-lock reset sequencer plus VDG pixel enable and 6809 E/Q quadrature enables.
// Latency: sys_reset releases LOCK_HOLD cycles after lock; ce_* decode same cycle, cpu_e/cpu_q lag one cycle.
// Backpressure: none; free-running enables, mode changes take effect only at a period wrap.
module coco_clk_enables #(
    parameter int QUARTER   = 12,
    parameter int VDG_DIV   = 12,
    parameter int LOCK_HOLD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic turbo,
    output logic sys_reset,
    output logic ce_vdg,
    output logic ce_q_rise,
    output logic ce_e_rise,
    output logic ce_q_fall,
    output logic ce_e_fall,
    output logic cpu_e,
    output logic cpu_q,
    output logic turbo_active
);

    localparam int PH_W  = $clog2(4 * QUARTER);
    localparam int VDG_W = (VDG_DIV > 1) ? $clog2(VDG_DIV) : 1;
    localparam int LC_W  = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD + 1) : 1;

    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_HOLD);
    localparam logic [LC_W-1:0]  LOCK_PRE = LC_W'(LOCK_HOLD - 1);
    localparam logic [LC_W-1:0]  LC_ONE   = LC_W'(1);

    // Phase decode points for each mode; turbo halves every quarter-phase.
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [PH_W-1:0]  N_E_RISE    = PH_W'(QUARTER);
    localparam logic [PH_W-1:0]  N_Q_FALL    = PH_W'(2 * QUARTER);
    localparam logic [PH_W-1:0]  N_E_FALL    = PH_W'(3 * QUARTER);
    localparam logic [PH_W-1:0]  N_LAST      = PH_W'(4 * QUARTER - 1);
    localparam logic [PH_W-1:0]  T_E_RISE    = PH_W'(QUARTER / 2);
    localparam logic [PH_W-1:0]  T_Q_FALL    = PH_W'(QUARTER);
    localparam logic [PH_W-1:0]  T_E_FALL    = PH_W'(3 * QUARTER / 2);
    localparam logic [PH_W-1:0]  T_LAST      = PH_W'(2 * QUARTER - 1);

    localparam logic [VDG_W-1:0] VDG_ONE  = VDG_W'(1);
    localparam logic [VDG_W-1:0] VDG_LAST = VDG_W'(VDG_DIV - 1);

    logic [LC_W-1:0]  lock_cnt;
    logic [PH_W-1:0]  ph;
    logic [VDG_W-1:0] vdg_cnt;

    logic             hold_in;
    logic             running;
    logic             release_now;
    logic [PH_W-1:0]  e_rise_ph;
    logic [PH_W-1:0]  q_fall_ph;
    logic [PH_W-1:0]  e_fall_ph;
    logic [PH_W-1:0]  last_ph;
    logic             ph_wrap;

    assign hold_in     = rst | ~pll_locked;
    assign running     = ~sys_reset;
    // Last HOLD cycle before the counter reaches LOCK_HOLD: the entry edge.
    assign release_now = sys_reset & ~hold_in & (lock_cnt == LOCK_PRE);

    // Lock filter: count consecutive locked cycles, drop sys_reset when the count lands on LOCK_HOLD.
    always_ff @(posedge clk) begin
        if (hold_in) begin
            lock_cnt  <= '0;
            sys_reset <= 1'b1;
        end else begin
            if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + LC_ONE;
            end
            if (lock_cnt == LOCK_PRE) begin
                sys_reset <= 1'b0;
            end
        end
    end

    // Select the decode points for the mode latched at the last wrap.
    always_comb begin
        e_rise_ph = N_E_RISE;
        q_fall_ph = N_Q_FALL;
        e_fall_ph = N_E_FALL;
        last_ph   = N_LAST;
        if (turbo_active) begin
            e_rise_ph = T_E_RISE;
            q_fall_ph = T_Q_FALL;
            e_fall_ph = T_E_FALL;
            last_ph   = T_LAST;
        end
        ph_wrap = (ph == last_ph);
    end

    // Single-cycle enables are decodes of the registered counters, gated off in HOLD.
    always_comb begin
        ce_q_rise = running & (ph == '0);
        ce_e_rise = running & (ph == e_rise_ph);
        ce_q_fall = running & (ph == q_fall_ph);
        ce_e_fall = running & (ph == e_fall_ph);
        ce_vdg    = running & (vdg_cnt == '0);
    end

    // Phase/VDG counters, E/Q levels and mode latch; all held at zero outside RUNNING.
    always_ff @(posedge clk) begin
        if (hold_in || sys_reset) begin
            ph           <= '0;
            vdg_cnt      <= '0;
            cpu_q        <= 1'b0;
            cpu_e        <= 1'b0;
            turbo_active <= release_now ? turbo : 1'b0;
        end else begin
            if (ph_wrap) begin
                ph           <= '0;
                turbo_active <= turbo;
            end else begin
                ph <= ph + PH_ONE;
            end

            if (vdg_cnt == VDG_LAST) begin
                vdg_cnt <= '0;
            end else begin
                vdg_cnt <= vdg_cnt + VDG_ONE;
            end

            if (ce_q_rise) begin
                cpu_q <= 1'b1;
            end else if (ce_q_fall) begin
                cpu_q <= 1'b0;
            end

            if (ce_e_rise) begin
                cpu_e <= 1'b1;
            end else if (ce_e_fall) begin
                cpu_e <= 1'b0;
            end
        end
    end

endmodule
